// File: rtl/crc16_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc16_sched_pkg
// Purpose  : Shared types and constants for the CRC-16-CCITT scheduler.
//            CRC16_SCHED_INIT_ONES_EN selects INIT=FFFF (CCITT-FALSE),
//            otherwise INIT=0000 (XMODEM).
// Revision : 1.0 - initial release
// ============================================================================
package crc16_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam int              CRC_W    = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
`ifdef CRC16_SCHED_INIT_ONES_EN
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
`else
    localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;
`endif

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic             b);
        logic f;
        f = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (f ? CRC_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc16_serial.sv
`default_nettype none
// ============================================================================
// Module   : crc16_serial
// Purpose  : Bit-serial CRC-16 register; init_load has priority over shift_en.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_serial
    import crc16_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_load,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= '0;
        end else if (init_load) begin
            r_crc <= CRC_INIT;
        end else if (shift_en) begin
            r_crc <= crc_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/crc16_sched.sv
`default_nettype none
// ============================================================================
// Module   : crc16_sched
// Purpose  : Round-robin scheduler feeding two byte streams through a shared
//            bit-serial CRC-16 engine. Build macro: CRC16_SCHED_INIT_ONES_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crc16_sched
    import crc16_sched_pkg::*;
#(
    parameter int FRAME_TIMEOUT = 255
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_data,
    input  logic             req0_sof,
    input  logic             req0_eof,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_data,
    input  logic             req1_sof,
    input  logic             req1_eof,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CRC_W-1:0] res_crc,
    output logic             res_id,
    output logic             res_abort,
    output logic             busy
);

    localparam logic [15:0] c_timeout = 16'(FRAME_TIMEOUT);

    state_t           r_state, w_next;
    logic             r_grant, r_last, r_disc0, r_disc1, r_eof;
    logic [7:0]       r_byte;
    logic [2:0]       r_bit_cnt;
    logic [15:0]      r_idle_cnt;
    logic [CRC_W-1:0] r_res_crc, w_crc;
    logic             r_res_id, r_res_abort;

    logic             w_open, w_hs, w_elig0, w_elig1, w_gnt_id, w_timeout;
    logic             w_sel_valid, w_sel_sof, w_sel_eof, w_bit_in;
    logic [7:0]       w_sel_data;

    // Ready is decoded purely from registered state so valid never reaches ready.
    assign w_open     = (r_state == ST_LOAD) || (r_state == ST_WAIT);
    assign req0_ready = (w_open && !r_grant) || r_disc0;
    assign req1_ready = (w_open &&  r_grant) || r_disc1;

    assign w_sel_valid = r_grant ? req1_valid : req0_valid;
    assign w_sel_data  = r_grant ? req1_data  : req0_data;
    assign w_sel_sof   = r_grant ? req1_sof   : req0_sof;
    assign w_sel_eof   = r_grant ? req1_eof   : req0_eof;
    assign w_hs        = w_open && w_sel_valid;

    assign w_elig0   = req0_valid && req0_sof;
    assign w_elig1   = req1_valid && req1_sof;
    assign w_gnt_id  = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
    assign w_timeout = (r_state == ST_WAIT) && !w_hs && (r_idle_cnt == c_timeout);
    assign w_bit_in  = r_byte[r_bit_cnt];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_elig0 || w_elig1) w_next = ST_LOAD;
            ST_LOAD:   if (w_hs) w_next = ST_SHIFT;
            ST_SHIFT:  if (r_bit_cnt == 3'd0) w_next = r_eof ? ST_RESULT : ST_WAIT;
            ST_WAIT: begin
                if (w_hs)           w_next = ST_SHIFT;
                else if (w_timeout) w_next = ST_RESULT;
            end
            ST_RESULT: if (res_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= 1'b0;
            r_last      <= 1'b1;
            r_disc0     <= 1'b0;
            r_disc1     <= 1'b0;
            r_eof       <= 1'b0;
            r_byte      <= '0;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_res_crc   <= '0;
            r_res_id    <= 1'b0;
            r_res_abort <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && (w_elig0 || w_elig1)) r_grant <= w_gnt_id;
            if (w_hs) begin
                r_byte    <= w_sel_data;
                r_eof     <= w_sel_eof;
                r_bit_cnt <= 3'd7;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
            end
            r_idle_cnt <= (r_state == ST_WAIT) ? r_idle_cnt + 16'd1 : 16'd0;
            // Discard pulse: one-cycle ready for a stray non-sof byte while idle.
            r_disc0 <= (r_state == ST_IDLE) && (w_next == ST_IDLE) &&
                       req0_valid && !req0_sof && !r_disc0;
            r_disc1 <= (r_state == ST_IDLE) && (w_next == ST_IDLE) &&
                       req1_valid && !req1_sof && !r_disc1;
            if (r_state != ST_RESULT && w_next == ST_RESULT) begin
                r_res_id    <= r_grant;
                r_res_abort <= (r_state == ST_WAIT);
                r_res_crc   <= (r_state == ST_WAIT) ? w_crc : crc_step(w_crc, w_bit_in);
            end
            if (r_state == ST_RESULT && res_ready) r_last <= r_res_id;
        end
    end

    crc16_serial u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_load (w_hs && w_sel_sof),
        .shift_en  (r_state == ST_SHIFT),
        .bit_in    (w_bit_in),
        .crc       (w_crc)
    );

    assign res_valid = (r_state == ST_RESULT);
    assign res_crc   = r_res_crc;
    assign res_id    = r_res_id;
    assign res_abort = r_res_abort;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
